// File: rtl/gpu_dec_pkg.sv
// Shared opcodes, ALU control codes and entry layout for the pipelined draw-instruction decoder.
package gpu_dec_pkg;

    localparam logic [1:0] OP_LD   = 2'd0;
    localparam logic [1:0] OP_RD   = 2'd1;
    localparam logic [1:0] OP_CD   = 2'd2;
    localparam logic [1:0] OP_DISP = 2'd3;

    localparam logic [2:0] ALU_LD   = 3'b100;
    localparam logic [2:0] ALU_RD   = 3'b101;
    localparam logic [2:0] ALU_CD   = 3'b110;
    localparam logic [2:0] ALU_DISP = 3'b111;

    localparam int unsigned DEC_X_W = 9;
    localparam int unsigned DEC_Y_W = 8;

    // Entry layout at the default coordinate widths.
    typedef struct packed {
        logic [2:0]         ctrl;
        logic [DEC_X_W-1:0] x1;
        logic [DEC_Y_W-1:0] y1;
        logic [DEC_X_W-1:0] x2;
        logic [DEC_Y_W-1:0] y2;
        logic               illegal;
    } dec_entry_t;

    function automatic logic [2:0] alu_ctrl(input logic [1:0] op);
        logic [2:0] ctrl;
        case (op)
            OP_LD:   ctrl = ALU_LD;
            OP_RD:   ctrl = ALU_RD;
            OP_CD:   ctrl = ALU_CD;
            default: ctrl = ALU_DISP;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/dec_skid_buf.sv
// Generic 2-entry valid/ready buffer; the main entry drives the outputs, the skid entry
// absorbs one word while the consumer stalls. in_ready is a flop, never a function of i_ready.
module dec_skid_buf #(
    parameter int unsigned         DATA_W    = 8,
    parameter logic [DATA_W-1:0]   RESET_VAL = '0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic              w_acc;
    logic              w_drn;
    logic              w_ld_main_in;
    logic              w_ld_main_skid;
    logic              w_ld_skid;

    assign w_acc = i_valid && r_in_ready;
    assign w_drn = r_out_valid && i_ready;

    always_comb begin
        w_state_next   = r_state;
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_acc) begin
                    w_ld_main_in = 1'b1;
                    w_state_next = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_acc && w_drn) begin
                    w_ld_main_in = 1'b1;
                end else if (w_acc) begin
                    w_ld_skid    = 1'b1;
                    w_state_next = ST_FULL;
                end else if (w_drn) begin
                    w_state_next = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_drn) begin
                    w_ld_main_skid = 1'b1;
                    w_state_next   = ST_ONE;
                end
            end
            default: w_state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_in_ready  <= (w_state_next != ST_FULL);
            r_out_valid <= (w_state_next != ST_EMPTY);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_main <= RESET_VAL;
            r_skid <= RESET_VAL;
        end else begin
            if (w_ld_main_in) begin
                r_main <= i_data;
            end else if (w_ld_main_skid) begin
                r_main <= r_skid;
            end
            if (w_ld_skid) begin
                r_skid <= i_data;
            end
        end
    end

    assign o_ready = r_in_ready;
    assign o_valid = r_out_valid;
    assign o_data  = r_main;

endmodule

// File: rtl/gpu_instr_decoder_pipe.sv
// Registered draw-instruction decoder with a 2-entry skid buffer towards the rasteriser ALU.
// Optional macro DEC_NORMALIZE_EN orders LD/RD/CD coordinates so that x1<=x2 and y1<=y2.
module gpu_instr_decoder_pipe
    import gpu_dec_pkg::*;
#(
    parameter int unsigned X_W   = 9,
    parameter int unsigned Y_W   = 8,
    parameter int unsigned OP_W  = 2,
    parameter int unsigned CNT_W = 16,
    localparam int unsigned INSTR_W = OP_W + 2 * (X_W + Y_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2:0]         ctrl_ALU,
    output logic [X_W-1:0]     x1,
    output logic [X_W-1:0]     x2,
    output logic [Y_W-1:0]     y1,
    output logic [Y_W-1:0]     y2,
    output logic               illegal,
    output logic [CNT_W-1:0]   dec_count
);

    typedef struct packed {
        logic [2:0]     ctrl;
        logic [X_W-1:0] x1;
        logic [Y_W-1:0] y1;
        logic [X_W-1:0] x2;
        logic [Y_W-1:0] y2;
        logic           illegal;
    } entry_t;

    localparam int unsigned ENTRY_W = $bits(entry_t);
    localparam entry_t ENTRY_RST = '{ctrl: ALU_DISP, x1: '0, y1: '0, x2: '0, y2: '0,
                                     illegal: 1'b0};

    logic [OP_W-1:0]  w_op;
    logic [X_W-1:0]   w_f_x1, w_f_x2, w_n_x1, w_n_x2;
    logic [Y_W-1:0]   w_f_y1, w_f_y2, w_n_y1, w_n_y2;
    logic             w_illegal;
    logic             w_coord_upd;
    logic             w_acc;
    entry_t           w_entry;
    entry_t           w_out;
    logic [X_W-1:0]   r_last_x1, r_last_x2;
    logic [Y_W-1:0]   r_last_y1, r_last_y2;
    logic [CNT_W-1:0] r_count;

    assign w_op   = in_instr[INSTR_W-1 -: OP_W];
    assign w_f_x1 = in_instr[2*X_W+2*Y_W-1 -: X_W];
    assign w_f_y1 = in_instr[X_W+2*Y_W-1 -: Y_W];
    assign w_f_x2 = in_instr[X_W+Y_W-1 -: X_W];
    assign w_f_y2 = in_instr[Y_W-1:0];

    generate
        if (OP_W > 2) begin : g_wide_op
            assign w_illegal = |w_op[OP_W-1:2];
        end else begin : g_narrow_op
            assign w_illegal = 1'b0;
        end
    endgenerate

`ifdef DEC_NORMALIZE_EN
    assign w_n_x1 = (w_f_x1 > w_f_x2) ? w_f_x2 : w_f_x1;
    assign w_n_x2 = (w_f_x1 > w_f_x2) ? w_f_x1 : w_f_x2;
    assign w_n_y1 = (w_f_y1 > w_f_y2) ? w_f_y2 : w_f_y1;
    assign w_n_y2 = (w_f_y1 > w_f_y2) ? w_f_y1 : w_f_y2;
`else
    assign w_n_x1 = w_f_x1;
    assign w_n_x2 = w_f_x2;
    assign w_n_y1 = w_f_y1;
    assign w_n_y2 = w_f_y2;
`endif

    // LD/RD/CD carry their own coordinates; DISP and illegal opcodes replay the last ones.
    assign w_coord_upd = !w_illegal && (w_op[1:0] != OP_DISP);

    always_comb begin
        w_entry.ctrl    = ALU_DISP;
        w_entry.x1      = r_last_x1;
        w_entry.y1      = r_last_y1;
        w_entry.x2      = r_last_x2;
        w_entry.y2      = r_last_y2;
        w_entry.illegal = w_illegal;
        if (w_coord_upd) begin
            w_entry.ctrl = alu_ctrl(w_op[1:0]);
            w_entry.x1   = w_n_x1;
            w_entry.y1   = w_n_y1;
            w_entry.x2   = w_n_x2;
            w_entry.y2   = w_n_y2;
        end
    end

    assign w_acc = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_x1 <= '0;
            r_last_y1 <= '0;
            r_last_x2 <= '0;
            r_last_y2 <= '0;
        end else if (w_acc && w_coord_upd) begin
            r_last_x1 <= w_n_x1;
            r_last_y1 <= w_n_y1;
            r_last_x2 <= w_n_x2;
            r_last_y2 <= w_n_y2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_acc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    dec_skid_buf #(
        .DATA_W    (ENTRY_W),
        .RESET_VAL (ENTRY_RST)
    ) u_skid (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_data  (w_entry),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (w_out)
    );

    assign ctrl_ALU  = w_out.ctrl;
    assign x1        = w_out.x1;
    assign y1        = w_out.y1;
    assign x2        = w_out.x2;
    assign y2        = w_out.y2;
    assign illegal   = w_out.illegal;
    assign dec_count = r_count;

endmodule

// File: tb/tb_gpu_instr_decoder_pipe.sv
// Self-checking bench for gpu_instr_decoder_pipe: directed vector table, hand-written
// back-pressure/reset sequences and random traffic against a queue-based reference model.
module tb_gpu_instr_decoder_pipe;
    import gpu_dec_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [35:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  ctrl_ALU;
    logic [8:0]  x1, x2;
    logic [7:0]  y1, y2;
    logic        illegal;
    logic [15:0] dec_count;

    gpu_instr_decoder_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ctrl_ALU  (ctrl_ALU),
        .x1        (x1),
        .x2        (x2),
        .y1        (y1),
        .y2        (y2),
        .illegal   (illegal),
        .dec_count (dec_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: FIFO of expected entries, last LD/RD/CD coordinates, word count.
    dec_entry_t q_exp[$];
    logic [8:0] m_x1, m_x2;
    logic [7:0] m_y1, m_y2;
    int         m_count;
    int         n_pop;
    bit         m_pushed;

    typedef struct {
        logic [1:0] op;
        logic [8:0] fx1;
        logic [7:0] fy1;
        logic [8:0] fx2;
        logic [7:0] fy2;
        dec_entry_t exp;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [35:0] pack(input logic [1:0] op, input logic [8:0] a,
                                         input logic [7:0] b, input logic [8:0] c,
                                         input logic [7:0] d);
        return {op, a, b, c, d};
    endfunction

    function automatic dec_entry_t model_decode(input logic [35:0] w);
        dec_entry_t e;
        logic [8:0] a, c, t9;
        logic [7:0] b, d, t8;
        a = w[33:25];
        b = w[24:17];
        c = w[16:8];
        d = w[7:0];
        e.illegal = 1'b0;
        if (w[35:34] == 2'd3) begin
            e.ctrl = 3'b111;
            e.x1 = m_x1; e.y1 = m_y1; e.x2 = m_x2; e.y2 = m_y2;
        end else begin
`ifdef DEC_NORMALIZE_EN
            if (a > c) begin t9 = a; a = c; c = t9; end
            if (b > d) begin t8 = b; b = d; d = t8; end
`else
            t9 = '0;
            t8 = '0;
`endif
            e.ctrl = 3'd4 + {1'b0, w[35:34]};
            e.x1 = a; e.y1 = b; e.x2 = c; e.y2 = d;
        end
        return e;
    endfunction

    function automatic logic [63:0] dut_entry();
        dec_entry_t e;
        e = '{ctrl: ctrl_ALU, x1: x1, y1: y1, x2: x2, y2: y2, illegal: illegal};
        return 64'(e);
    endfunction

    task automatic model_reset();
        q_exp.delete();
        m_x1 = '0; m_x2 = '0; m_y1 = '0; m_y2 = '0;
        m_count = 0;
    endtask

    // Called at the falling edge: check state, then book the transfers of the next rising edge.
    task automatic monitor();
        dec_entry_t e;
        chk("out_valid", 64'(out_valid), 64'(q_exp.size() > 0));
        chk("in_ready", 64'(in_ready), 64'(q_exp.size() < 2));
        chk("dec_count", 64'(dec_count), 64'(m_count));
        if (q_exp.size() > 0) chk("entry", dut_entry(), 64'(q_exp[0]));
        m_pushed = 1'b0;
        if (out_valid && out_ready && q_exp.size() > 0) begin
            void'(q_exp.pop_front());
            n_pop++;
        end
        if (in_valid && in_ready) begin
            e = model_decode(in_instr);
            q_exp.push_back(e);
            if (e.ctrl != 3'b111) begin
                m_x1 = e.x1; m_y1 = e.y1; m_x2 = e.x2; m_y2 = e.y2;
            end
            if (m_count < 65535) m_count++;
            m_pushed = 1'b1;
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[7];
    int   pops0;
    int   drops;
    bit   got;

    initial begin
        vecs[0] = '{2'd0, 9'd5, 8'd10, 9'd100, 8'd200, '{3'b100, 9'd5, 8'd10, 9'd100, 8'd200, 1'b0}};
        vecs[1] = '{2'd3, 9'h1AB, 8'h77, 9'h00F, 8'hEE, '{3'b111, 9'd5, 8'd10, 9'd100, 8'd200, 1'b0}};
        vecs[2] = '{2'd0, 9'd10, 8'd20, 9'd30, 8'd40, '{3'b100, 9'd10, 8'd20, 9'd30, 8'd40, 1'b0}};
        vecs[3] = '{2'd3, 9'd1, 8'd2, 9'd3, 8'd4, '{3'b111, 9'd10, 8'd20, 9'd30, 8'd40, 1'b0}};
`ifdef DEC_NORMALIZE_EN
        vecs[4] = '{2'd1, 9'd7, 8'd8, 9'd9, 8'd6, '{3'b101, 9'd7, 8'd6, 9'd9, 8'd8, 1'b0}};
        vecs[5] = '{2'd2, 9'd300, 8'd50, 9'd20, 8'd60, '{3'b110, 9'd20, 8'd50, 9'd300, 8'd60, 1'b0}};
        vecs[6] = '{2'd3, 9'd0, 8'd0, 9'd0, 8'd0, '{3'b111, 9'd20, 8'd50, 9'd300, 8'd60, 1'b0}};
`else
        vecs[4] = '{2'd1, 9'd7, 8'd8, 9'd9, 8'd6, '{3'b101, 9'd7, 8'd8, 9'd9, 8'd6, 1'b0}};
        vecs[5] = '{2'd2, 9'd300, 8'd50, 9'd20, 8'd60, '{3'b110, 9'd300, 8'd50, 9'd20, 8'd60, 1'b0}};
        vecs[6] = '{2'd3, 9'd0, 8'd0, 9'd0, 8'd0, '{3'b111, 9'd300, 8'd50, 9'd20, 8'd60, 1'b0}};
`endif
        n_pop = 0;
        model_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_instr = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst in_ready", 64'(in_ready), 64'd1);
        chk("rst entry", dut_entry(), 64'({3'b111, 35'd0}));
        chk("rst dec_count", 64'(dec_count), 64'd0);

        // Directed table, one word per cycle with the ALU always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_instr = pack(vecs[i].op, vecs[i].fx1, vecs[i].fy1, vecs[i].fx2, vecs[i].fy2);
            step();
            in_valid = 1'b0;
            chk("vec out_valid", 64'(out_valid), 64'd1);
            chk("vec entry", dut_entry(), 64'(vecs[i].exp));
            chk("vec dec_count", 64'(dec_count), 64'(i + 1));
        end
        repeat (2) step();

        // Back-pressure: two words fill the buffer, the third stalls until a drain.
        out_ready = 1'b0;
        pops0 = n_pop;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_instr = pack(2'(i), 9'(11 * (i + 1)), 8'(i + 1), 9'(i + 2), 8'(i + 3));
            step();
        end
        chk("stall in_ready", 64'(in_ready), 64'd0);
        chk("stall head x1", 64'(x1), 64'd11);
        out_ready = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            step();
            got = m_pushed;
        end
        chk("third word accepted", 64'(got), 64'd1);
        in_valid = 1'b0;
        repeat (4) step();
        chk("stall drain count", 64'(n_pop - pops0), 64'd3);

        // Continuous stream: one word per cycle, in_ready never drops.
        pops0 = n_pop;
        drops = 0;
        for (int i = 0; i < 50; i++) begin
            in_valid = 1'b1;
            in_instr = {$urandom_range(0, 3), $urandom()} & 36'hF_FFFF_FFFF;
            in_instr[35:34] = 2'($urandom_range(0, 3));
            step();
            if (!m_pushed) drops++;
        end
        in_valid = 1'b0;
        repeat (2) step();
        chk("stream drops", 64'(drops), 64'd0);
        chk("stream outputs", 64'(n_pop - pops0), 64'd50);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 9) < 7);
            in_instr = {2'($urandom_range(0, 3)), 9'($urandom()), 8'($urandom()),
                        9'($urandom()), 8'($urandom())};
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();

        // Reset while FULL discards everything, including the last-coord register.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_instr = pack(2'd0, 9'd77, 8'd66, 9'd55, 8'd44);
            step();
        end
        in_valid = 1'b0;
        chk("full before reset", 64'(in_ready), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst out_valid", 64'(out_valid), 64'd0);
        chk("async rst in_ready", 64'(in_ready), 64'd1);
        chk("async rst dec_count", 64'(dec_count), 64'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) step();
        in_valid = 1'b1;
        in_instr = pack(2'd3, 9'd9, 8'd9, 9'd9, 8'd9);
        step();
        in_valid = 1'b0;
        chk("post-reset DISP", dut_entry(), 64'({3'b111, 35'd0}));
        chk("post-reset count", 64'(dec_count), 64'd1);
        repeat (2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
